// File: rtl/kernel_jtag_scan_pkg.sv
// rtl/kernel_jtag_scan_pkg.sv - shared state type, widths and IR encodings for the virtual JTAG scan master
package kernel_jtag_scan_pkg;

  localparam int SR_W     = 38;
  localparam int IR_W     = 2;
  localparam int BITCNT_W = 6;

  localparam logic [BITCNT_W-1:0] BITCNT_LAST = BITCNT_W'(SR_W - 1);

  localparam logic [IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } scan_state_e;

endpackage

// File: rtl/kernel_jtag_scan_tck_gen.sv
// rtl/kernel_jtag_scan_tck_gen.sv - TCK generator: low for TCK_DIV clk, high for TCK_DIV clk, parked low when disabled
module kernel_jtag_scan_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic period_start,
  output logic pre_rise
);

  localparam int CNT_W = $clog2(2 * TCK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(TCK_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  // TCK is registered so it never glitches; the counter restarts at 0 whenever the master is idle.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      tck <= (cnt_nxt >= CNT_HIGH);
    end
  end

  // period_start marks the cycle whose closing edge is TCK's falling position (start of the next period).
  assign period_start = en && (cnt == CNT_LAST);
  assign pre_rise     = en && (cnt == CNT_RISE);

endmodule

// File: rtl/kernel_jtag_debug_scan_master.sv
// rtl/kernel_jtag_debug_scan_master.sv - virtual JTAG scan master; TDO/IR_OUT capture built only with KERNEL_JTAG_SCAN_CAPTURE_EN
module kernel_jtag_debug_scan_master
  import kernel_jtag_scan_pkg::*;
#(
  parameter int TCK_DIV     = 2,
  parameter int RTI_PERIODS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [SR_W-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SR_W-1:0] rsp_data,
  output logic [IR_W-1:0] rsp_ir,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  if (TCK_DIV < 2) begin : g_bad_tck_div
    $error("kernel_jtag_debug_scan_master: TCK_DIV must be >= 2");
  end
  if (RTI_PERIODS < 1) begin : g_bad_rti
    $error("kernel_jtag_debug_scan_master: RTI_PERIODS must be >= 1");
  end

  localparam int RTI_W = $clog2(RTI_PERIODS) + 1;
  localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'(RTI_PERIODS - 1);

  scan_state_e         state_q, state_d;
  logic [IR_W-1:0]     ir_q;
  logic [SR_W-1:0]     shift_q;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [RTI_W-1:0]    rti_cnt;
  logic                scan_active;
  logic                period_start;
  logic                pre_rise;

  kernel_jtag_scan_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk         (clk),
    .reset       (reset),
    .en          (scan_active),
    .tck         (vji_tck),
    .period_start(period_start),
    .pre_rise    (pre_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_active = 1'b0;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    vji_uir     = 1'b0;
    vji_cdr     = 1'b0;
    vji_sdr     = 1'b0;
    vji_udr     = 1'b0;
    vji_rti     = 1'b0;
    vji_tdi     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_UIR;
      end
      ST_UIR: begin
        scan_active = 1'b1;
        vji_uir     = 1'b1;
        if (period_start) state_d = ST_CDR;
      end
      ST_CDR: begin
        scan_active = 1'b1;
        vji_cdr     = 1'b1;
        if (period_start) state_d = ST_SDR;
      end
      ST_SDR: begin
        scan_active = 1'b1;
        vji_sdr     = 1'b1;
        vji_tdi     = shift_q[0];
        if (period_start && bit_cnt == BITCNT_LAST) state_d = ST_UDR;
      end
      ST_UDR: begin
        scan_active = 1'b1;
        vji_udr     = 1'b1;
        if (period_start) state_d = ST_RTI;
      end
      ST_RTI: begin
        scan_active = 1'b1;
        vji_rti     = 1'b1;
        if (period_start && rti_cnt == RTI_LAST) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register only moves on the falling-position edge, so TDI holds for a full TCK period.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= '0;
      shift_q <= '0;
      bit_cnt <= '0;
      rti_cnt <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            ir_q    <= cmd_ir;
            shift_q <= cmd_data;
          end
        end
        ST_CDR: bit_cnt <= '0;
        ST_SDR: begin
          if (period_start) begin
            shift_q <= {1'b0, shift_q[SR_W-1:1]};
            if (bit_cnt != BITCNT_LAST) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_UDR: rti_cnt <= '0;
        ST_RTI: begin
          if (period_start) rti_cnt <= rti_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign vji_ir_in = ir_q;

`ifdef KERNEL_JTAG_SCAN_CAPTURE_EN
  logic [SR_W-1:0] cap_q;
  logic [IR_W-1:0] rsp_ir_q;

  // Samples land MSB-first and walk down, so after 38 periods bit k holds period k's TDO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q    <= '0;
      rsp_ir_q <= '0;
    end else if (pre_rise) begin
      if (state_q == ST_SDR) cap_q <= {vji_tdo, cap_q[SR_W-1:1]};
      if (state_q == ST_UDR) rsp_ir_q <= vji_ir_out;
    end
  end

  assign rsp_data = cap_q;
  assign rsp_ir   = rsp_ir_q;
`else
  logic unused_capture_inputs;
  assign unused_capture_inputs = ^{vji_tdo, vji_ir_out, pre_rise};
  assign rsp_data = '0;
  assign rsp_ir   = '0;
`endif

endmodule

// File: tb/tb_kernel_jtag_debug_scan_master.sv
// tb/tb_kernel_jtag_debug_scan_master.sv - bench for kernel_jtag_debug_scan_master, default and TCK_DIV=4/RTI_PERIODS=3 builds
module tb_kernel_jtag_debug_scan_master;
  import kernel_jtag_scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        c0_valid, c0_ready, r0_valid, r0_ready;
  logic [1:0]  c0_ir, r0_ir, ir_in0, ir_out0;
  logic [37:0] c0_data, r0_data;
  logic        tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;

  logic        c1_valid, c1_ready, r1_valid, r1_ready;
  logic [1:0]  c1_ir, r1_ir, ir_in1, ir_out1;
  logic [37:0] c1_data, r1_data;
  logic        tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;

  kernel_jtag_debug_scan_master u0 (
    .clk(clk), .reset(reset), .cmd_valid(c0_valid), .cmd_ready(c0_ready),
    .cmd_ir(c0_ir), .cmd_data(c0_data), .rsp_valid(r0_valid), .rsp_ready(r0_ready),
    .rsp_data(r0_data), .rsp_ir(r0_ir), .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0),
    .vji_ir_in(ir_in0), .vji_ir_out(ir_out0), .vji_uir(uir0), .vji_cdr(cdr0),
    .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0)
  );

  kernel_jtag_debug_scan_master #(.TCK_DIV(4), .RTI_PERIODS(3)) u1 (
    .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_ir(c1_ir), .cmd_data(c1_data), .rsp_valid(r1_valid), .rsp_ready(r1_ready),
    .rsp_data(r1_data), .rsp_ir(r1_ir), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
    .vji_ir_in(ir_in1), .vji_ir_out(ir_out1), .vji_uir(uir1), .vji_cdr(cdr1),
    .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
  );

  // Target: a one-stage TDI->TDO loop loaded with 1 at the CDR rise.
  logic tgt0 = 1'b0;
  int   sdr_rise0 = 0;
  always @(posedge tck0) begin
    if (sdr0) begin
      tgt0      <= tdi0;
      sdr_rise0 <= sdr_rise0 + 1;
    end else if (cdr0) begin
      tgt0 <= 1'b1;
    end
  end
  assign tdo0    = tgt0;
  assign tdo1    = 1'b0;
  assign ir_out1 = 2'b10;

  int         uir_cyc0 = 0, uir_pulse0 = 0;
  logic       uir0_d = 1'b0;
  logic [1:0] uir_ir0 = 2'b00;
  int         uir_cyc1 = 0, cdr_cyc1 = 0, sdr_cyc1 = 0, rti_cyc1 = 0;
  always @(negedge clk) begin
    if (uir0) begin
      uir_cyc0 <= uir_cyc0 + 1;
      uir_ir0  <= ir_in0;
      if (!uir0_d) uir_pulse0 <= uir_pulse0 + 1;
    end
    uir0_d <= uir0;
    if (uir1) uir_cyc1 <= uir_cyc1 + 1;
    if (cdr1) cdr_cyc1 <= cdr_cyc1 + 1;
    if (sdr1) sdr_cyc1 <= sdr_cyc1 + 1;
    if (rti1) rti_cyc1 <= rti_cyc1 + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scan0(input logic [1:0] ir, input logic [37:0] data, input logic [1:0] iro, input bit bp);
    int          lat;
    int          u_c, u_p, s_r;
    logic [37:0] exp_d, held;
    logic [1:0]  exp_ir;
    bit          stable_ok;
`ifdef KERNEL_JTAG_SCAN_CAPTURE_EN
    exp_d  = {data[36:0], 1'b1};
    exp_ir = iro;
`else
    exp_d  = '0;
    exp_ir = '0;
`endif
    @(negedge clk);
    u_c = uir_cyc0;
    u_p = uir_pulse0;
    s_r = sdr_rise0;
    check("idle_ready", c0_ready, 1);
    c0_valid = 1'b1;
    c0_ir    = ir;
    c0_data  = data;
    ir_out0  = iro;
    @(negedge clk);
    c0_valid = 1'b0;
    c0_ir    = ~ir;
    c0_data  = ~data;
    lat      = 1;
    while (!r0_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
      c0_valid = (lat == 50);
    end
    c0_valid = 1'b0;
    check("latency", lat, 169);
    check("rsp_data", r0_data, exp_d);
    check("rsp_ir", r0_ir, exp_ir);
    check("uir_pulses", uir_pulse0 - u_p, 1);
    check("uir_width", uir_cyc0 - u_c, 4);
    check("uir_ir_in", uir_ir0, ir);
    check("sdr_rises", sdr_rise0 - s_r, 38);
    check("resp_strobes", {uir0, cdr0, sdr0, udr0, rti0, tck0}, 0);
    if (bp) begin
      held      = r0_data;
      stable_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        c0_valid = (i == 20);
        c0_data  = 38'(i);
        if (r0_data !== held || tck0 !== 1'b0 || c0_ready !== 1'b0 || r0_valid !== 1'b1) stable_ok = 1'b0;
      end
      c0_valid = 1'b0;
      check("bp_stable", stable_ok, 1);
    end
    r0_ready = 1'b1;
    @(negedge clk);
    r0_ready = 1'b0;
    check("release_ready", c0_ready, 1);
    check("release_valid", r0_valid, 0);
    repeat (3) @(negedge clk);
    check("no_stray_accept", {c0_ready, uir0}, 2'b10);
  endtask

  initial begin
    logic [63:0] rnd;
    logic [1:0]  ir_tbl [4];
    int          w, lat, u_c, c_c, s_c, r_c;
    bit          quiet;
    ir_tbl[0] = IR_OCIMEM;
    ir_tbl[1] = IR_TRACEMEM;
    ir_tbl[2] = IR_BREAK;
    ir_tbl[3] = IR_TRACECTRL;
    reset = 1'b1;
    c0_valid = 1'b0; c0_ir = '0; c0_data = '0; r0_ready = 1'b0; ir_out0 = '0;
    c1_valid = 1'b0; c1_ir = '0; c1_data = '0; r1_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", c0_ready, 1);
    check("rst_rsp_valid", r0_valid, 0);
    check("rst_rsp_data", r0_data, 0);
    check("rst_rsp_ir", r0_ir, 0);
    check("rst_tck_tdi", {tck0, tdi0}, 0);
    check("rst_ir_in", ir_in0, 0);
    check("rst_strobes", {uir0, cdr0, sdr0, udr0, rti0}, 0);
    check("rst_u1_ready", {c1_ready, r1_valid, tck1}, 3'b100);

    scan0(IR_BREAK, 38'h2_A5A5_5A5A, 2'b01, 1'b1);
    for (int n = 0; n < 3; n++) begin
      rnd = {$urandom(), $urandom()};
      scan0(ir_tbl[$urandom_range(0, 3)], rnd[37:0], 2'($urandom_range(0, 3)), 1'b0);
    end

    @(negedge clk);
    w = sdr_rise0;
    c0_valid = 1'b1;
    c0_ir    = IR_TRACEMEM;
    c0_data  = 38'h1_2345_6789;
    @(negedge clk);
    c0_valid = 1'b0;
    lat = 0;
    while (!(sdr0 && !tck0 && (sdr_rise0 - w) == 17) && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("mid_sdr_reached", lat < 1000, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {uir0, cdr0, sdr0, udr0, rti0, tck0}, 0);
    check("midrst_ir_in", ir_in0, 0);
    check("midrst_state", {c0_ready, r0_valid}, 2'b10);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r0_valid !== 1'b0 || uir0 !== 1'b0) quiet = 1'b0;
    end
    check("midrst_no_rsp", quiet, 1);
    rnd = {$urandom(), $urandom()};
    scan0(IR_OCIMEM, rnd[37:0], 2'b11, 1'b0);

    @(negedge clk);
    u_c = uir_cyc1; c_c = cdr_cyc1; s_c = sdr_cyc1; r_c = rti_cyc1;
    c1_valid = 1'b1;
    c1_ir    = IR_TRACECTRL;
    c1_data  = 38'h3_0F0F_F0F0;
    @(negedge clk);
    c1_valid = 1'b0;
    lat = 1;
    while (!r1_valid && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    check("u1_latency", lat, 353);
    check("u1_uir_width", uir_cyc1 - u_c, 8);
    check("u1_cdr_width", cdr_cyc1 - c_c, 8);
    check("u1_sdr_cycles", sdr_cyc1 - s_c, 304);
    check("u1_rti_cycles", rti_cyc1 - r_c, 24);
    check("u1_ir_in", ir_in1, IR_TRACECTRL);
`ifdef KERNEL_JTAG_SCAN_CAPTURE_EN
    check("u1_rsp_ir", r1_ir, 2'b10);
`else
    check("u1_rsp_ir", r1_ir, 2'b00);
`endif
    r1_ready = 1'b1;
    @(negedge clk);
    r1_ready = 1'b0;
    check("u1_release", {c1_ready, r1_valid}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
